// File: rtl/srec_boot_pkg.sv
// Shared types for the SREC boot controller: FSM state encoding and write-buffer entry layout.
// Latency: n/a (types only).  Backpressure: n/a.
package srec_boot_pkg;

    localparam int ENTRY_W    = 40;
    localparam int BYTE_CNT_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  dat;
    } fifo_entry_t;

endpackage

// File: rtl/srec_write_fifo.sv
// Synchronous write buffer with flush; head entry visible combinationally.
// Latency: push to non-empty head is 1 cycle.  Backpressure: caller must not push when full unless popping.
module srec_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // When full, push and pop share a slot: the head is read before the edge overwrites it.
    always_ff @(posedge clock) begin
        if (push && !flush) store[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = store[rd_ptr[AW-1:0]];

endmodule

// File: rtl/srec_boot_controller.sv
// Boot sequencer: buffers parser writes into memory, ends load on idle timeout, then releases the CPU.
// Latency: parser write to mem_write is 1 cycle; status registered.  Backpressure: mem_ready stalls the FIFO; parser cannot stall, so overrun is a FAIL.
// Optional SREC_BOOT_CONTROLLER_SUM_EN builds the image_sum adder.
module srec_boot_controller
    import srec_boot_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           wr_address,
    input  logic [7:0]            wr_byte,
    input  logic                  wr_enable,
    input  logic                  format_error,
    input  logic                  checksum_error,
    output logic                  parser_clear,
    output logic [31:0]           mem_address,
    output logic [7:0]            mem_wdata,
    output logic                  mem_write,
    input  logic                  mem_ready,
    input  logic [31:0]           cpu_address,
    input  logic                  cpu_req,
    output logic                  cpu_ack,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic                  overflow,
    output logic [BYTE_CNT_W-1:0] byte_count,
    output logic [15:0]           image_sum
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              pushed_any;
    logic              active;
    logic              start_acc;
    logic              err;
    logic              ovf_evt;
    logic              go_fail;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    fifo_entry_t       push_ent;
    fifo_entry_t       head_ent;
    logic [ENTRY_W-1:0] head_dat;

    assign active     = (state == ST_LOAD) || (state == ST_DRAIN);
    assign start_acc  = start && !active;
    assign err        = active && (format_error || checksum_error);
    assign fifo_pop   = active && !fifo_empty && mem_ready;
    assign ovf_evt    = active && wr_enable && fifo_full && !fifo_pop;
    assign fifo_push  = active && wr_enable && !ovf_evt;
    assign go_fail    = err || ovf_evt;
    assign fifo_flush = start_acc || go_fail;
    assign push_ent   = '{addr: wr_address, dat: wr_byte};
    assign head_ent   = head_dat;

    srec_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .push_dat (push_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

    // Errors take priority over the idle timeout and over a late parser write.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN, ST_FAIL: if (start_acc) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (go_fail)
                    state_nxt = ST_FAIL;
                else if (!wr_enable && pushed_any && idle_cnt == IDLE_LAST)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (go_fail)         state_nxt = ST_FAIL;
                else if (wr_enable)  state_nxt = ST_LOAD;
                else if (fifo_empty) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            idle_cnt     <= '0;
            pushed_any   <= 1'b0;
            byte_count   <= '0;
            parser_clear <= 1'b0;
            cpu_reset_n  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nxt;
            parser_clear <= start_acc;
            cpu_reset_n  <= (state_nxt == ST_RUN);
            busy         <= (state_nxt == ST_LOAD) || (state_nxt == ST_DRAIN);
            done         <= (state_nxt == ST_RUN);
            fail         <= (state_nxt == ST_FAIL);
            if (start_acc) begin
                idle_cnt   <= '0;
                pushed_any <= 1'b0;
                byte_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (ovf_evt) overflow <= 1'b1;
                if (active && wr_enable) begin
                    idle_cnt   <= '0;
                    pushed_any <= 1'b1;
                end else if (state == ST_LOAD && idle_cnt != IDLE_LAST) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
                if (fifo_pop && byte_count != '1)
                    byte_count <= byte_count + BYTE_CNT_W'(1);
            end
        end
    end

`ifdef SREC_BOOT_CONTROLLER_SUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      image_sum <= '0;
        else if (start_acc) image_sum <= '0;
        else if (fifo_pop)  image_sum <= image_sum + {8'h00, head_ent.dat};
    end
`else
    assign image_sum = '0;
`endif

    // Memory port: FIFO head while loading, CPU pass-through in RUN, idle otherwise.
    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        mem_write   = 1'b0;
        cpu_ack     = 1'b0;
        if (active) begin
            mem_write   = !fifo_empty;
            mem_address = head_ent.addr;
            mem_wdata   = head_ent.dat;
        end else if (state == ST_RUN) begin
            mem_address = cpu_address;
            cpu_ack     = cpu_req && mem_ready;
        end
    end

endmodule

// File: tb/tb_srec_boot_controller.sv
// Self-checking bench for srec_boot_controller (FIFO_DEPTH=4, IDLE_TIMEOUT=16).
// Memory writes are matched against a scoreboard queue; RUN-state routing is table driven.
module tb_srec_boot_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] wr_address;
    logic [7:0]  wr_byte;
    logic        wr_enable;
    logic        format_error;
    logic        checksum_error;
    logic        parser_clear;
    logic [31:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_write;
    logic        mem_ready;
    logic [31:0] cpu_address;
    logic        cpu_req;
    logic        cpu_ack;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        fail;
    logic        overflow;
    logic [23:0] byte_count;
    logic [15:0] image_sum;

    int total = 0;
    int bad   = 0;
    logic [39:0] sb[$];

    typedef struct {
        logic        cpu_req;
        logic [31:0] cpu_address;
        logic        mem_ready;
        logic [31:0] exp_addr;
        logic        exp_ack;
    } run_vec_t;

    run_vec_t    rv [4];
    logic [39:0] img [3];

    srec_boot_controller #(
        .FIFO_DEPTH   (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .wr_address     (wr_address),
        .wr_byte        (wr_byte),
        .wr_enable      (wr_enable),
        .format_error   (format_error),
        .checksum_error (checksum_error),
        .parser_clear   (parser_clear),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_write      (mem_write),
        .mem_ready      (mem_ready),
        .cpu_address    (cpu_address),
        .cpu_req        (cpu_req),
        .cpu_ack        (cpu_ack),
        .cpu_reset_n    (cpu_reset_n),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .overflow       (overflow),
        .byte_count     (byte_count),
        .image_sum      (image_sum)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d, input bit track);
        wr_address = a;
        wr_byte    = d;
        wr_enable  = 1'b1;
        if (track) sb.push_back({a, d});
        tick();
        wr_enable  = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) chk("wait_done_timeout", 64'(n), 64'(budget + 1));
    endtask

    // Every memory acceptance must match the oldest expected write.
    always @(negedge clock) begin
        if (reset_n && mem_write && mem_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_mem_write", {24'h0, mem_address, mem_wdata}, 64'h0);
            end else begin
                chk("mem_write_order", {24'h0, mem_address, mem_wdata}, {24'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] exp_sum;

        rv[0] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, 1'b1};
        rv[1] = '{1'b1, 32'h0000_0204, 1'b0, 32'h0000_0204, 1'b0};
        rv[2] = '{1'b0, 32'h0000_0300, 1'b1, 32'h0000_0300, 1'b0};
        rv[3] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1};
        img[0] = {32'h100, 8'hAA};
        img[1] = {32'h101, 8'hBB};
        img[2] = {32'h102, 8'hCC};
`ifdef SREC_BOOT_CONTROLLER_SUM_EN
        exp_sum = 16'h0231;
`else
        exp_sum = 16'h0000;
`endif

        reset_n = 1'b0; start = 1'b0; wr_address = '0; wr_byte = '0; wr_enable = 1'b0;
        format_error = 1'b0; checksum_error = 1'b0; mem_ready = 1'b0;
        cpu_address = '0; cpu_req = 1'b0;
        repeat (3) tick();
        chk("reset_flags", {cpu_reset_n, parser_clear, mem_write, cpu_ack, busy, done, fail, overflow}, 8'h00);
        chk("reset_byte_count", byte_count, 0);
        chk("reset_image_sum", image_sum, 0);
        reset_n = 1'b1;
        tick();

        // Basic image load, timeout, drain and handoff.
        mem_ready = 1'b1;
        do_start();
        chk("start_parser_clear", parser_clear, 1);
        chk("start_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            wr(img[i][39:8], img[i][7:0], 1'b1);
            if (i == 0) chk("push_to_write_latency", {mem_write, mem_address}, {1'b1, 32'h100});
        end
        chk("parser_clear_one_cycle", parser_clear, 0);
        wait_done(40, n);
        chk("idle_timeout_to_run_cycles", n, 17);
        chk("run_status", {busy, done, fail, cpu_reset_n}, 4'b0101);
        chk("run_byte_count", byte_count, 3);
        chk("run_image_sum", image_sum, exp_sum);
        chk("sb_empty_load1", sb.size(), 0);

        // CPU routing in RUN.
        for (int i = 0; i < 4; i++) begin
            cpu_req = rv[i].cpu_req; cpu_address = rv[i].cpu_address; mem_ready = rv[i].mem_ready;
            #1;
            chk("run_mem_address", mem_address, rv[i].exp_addr);
            chk("run_cpu_ack", cpu_ack, rv[i].exp_ack);
            chk("run_mem_write", mem_write, 0);
            tick();
        end
        cpu_req = 1'b0;

        // Full FIFO, then simultaneous push and pop with a full FIFO.
        mem_ready = 1'b0;
        do_start();
        chk("rerun_cpu_reset", {cpu_reset_n, busy, done}, 3'b010);
        chk("rerun_byte_count_clr", byte_count, 0);
        for (int i = 0; i < 4; i++) wr(32'h10 + 32'(i), 8'h50 + 8'(i), 1'b1);
        chk("full_no_overflow", {overflow, fail, mem_write}, 3'b001);
        chk("full_head_address", mem_address, 32'h10);
        mem_ready = 1'b1;
        wr(32'h14, 8'h54, 1'b1);
        chk("full_push_pop_ok", {overflow, fail, busy}, 3'b001);
        wait_done(60, n);
        chk("full_byte_count", byte_count, 5);
        chk("sb_empty_load2", sb.size(), 0);

        // Overflow: five writes with memory stalled.
        mem_ready = 1'b0;
        do_start();
        for (int i = 0; i < 5; i++) wr(32'h20 + 32'(i), 8'h60 + 8'(i), 1'b0);
        chk("ovf_status", {fail, overflow, busy, mem_write}, 4'b1100);
        mem_ready = 1'b1;
        #1;
        chk("fail_mem_idle", mem_write, 0);
        tick();

        // Start leaves FAIL; checksum error after two pops.
        do_start();
        chk("fail_restart", {busy, fail, overflow, parser_clear}, 4'b1001);
        wr(32'h40, 8'h01, 1'b1);
        wr(32'h41, 8'h02, 1'b1);
        tick();
        chk("pops_before_err", byte_count, 2);
        checksum_error = 1'b1;
        tick();
        chk("checksum_fail", {fail, busy, overflow}, 3'b100);
        start = 1'b1;
        tick();
        chk("start_beats_error", {busy, fail, parser_clear}, 3'b101);
        chk("restart_byte_count", byte_count, 0);
        start = 1'b0;
        checksum_error = 1'b0;
        tick();
        chk("restart_clear_drop", {parser_clear, busy}, 2'b01);
        repeat (30) tick();
        chk("no_bytes_stays_load", {busy, done}, 2'b10);

        // Reset in the middle of a load with two entries queued.
        mem_ready = 1'b0;
        wr(32'h80, 8'h11, 1'b0);
        wr(32'h81, 8'h22, 1'b0);
        chk("queued_before_reset", mem_write, 1);
        reset_n = 1'b0;
        #1;
        chk("midload_reset_flags", {cpu_reset_n, parser_clear, mem_write, cpu_ack, busy, done, fail, overflow}, 8'h00);
        chk("midload_reset_count", byte_count, 0);
        chk("midload_fifo_empty", dut.u_fifo.empty, 1);
        tick();
        reset_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("after_reset_idle", {busy, done, fail, mem_write}, 4'b0000);
        chk("sb_empty_final", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
